// File: rtl/md_defs_pkg.sv
// ============================================================================
// md_defs : shared op encodings, default latencies and EX result-mux selects
//           for the multiply/divide unit.
// Rev 1.0
// ============================================================================
`default_nettype none

package md_defs;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // EX-stage 4-input result mux: HI/LO occupy two of the four legs.
  typedef enum logic [1:0] {
    EX_SEL_ALU  = 2'd0,
    EX_SEL_HI   = 2'd1,
    EX_SEL_LO   = 2'd2,
    EX_SEL_LINK = 2'd3
  } ex_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit : multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// Rev 1.0
// ============================================================================
`default_nettype none

module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  // Result datapath, driven purely from the latched operands.
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;
  logic [31:0] res_hi, res_lo;
  logic        res_valid;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign b_zero     = (b_q == 32'd0);
  assign a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_u_safe   = b_zero ? 32'd1 : b_q;

  // Magnitude division; 0x80000000 / -1 naturally wraps back to 0x80000000.
  assign q_mag = a_mag / b_mag_safe;
  assign r_mag = a_mag % b_mag_safe;
  assign q_s   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_q[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = a_q / b_u_safe;
  assign r_u   = a_q % b_u_safe;

  always_comb begin
    res_hi    = hi_q;
    res_lo    = lo_q;
    res_valid = 1'b0;
    case (op_q)
      MD_MULT: begin
        res_hi    = prod_s[63:32];
        res_lo    = prod_s[31:0];
        res_valid = 1'b1;
      end
      MD_MULTU: begin
        res_hi    = prod_u[63:32];
        res_lo    = prod_u[31:0];
        res_valid = 1'b1;
      end
      MD_DIV: begin
        res_hi    = r_s;
        res_lo    = q_s;
        res_valid = !b_zero;
      end
      MD_DIVU: begin
        res_hi    = r_u;
        res_lo    = q_u;
        res_valid = !b_zero;
      end
      default: begin
        res_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start && (is_mult(md_op) || is_div(md_op))) begin
          state_d = MD_RUN;
          op_d    = md_op_e'(md_op);
          a_d     = rs_data;
          b_d     = rt_data;
          cnt_d   = is_mult(md_op) ? MULT_LOAD : DIV_LOAD;
        end else if (md_op == MD_MTHI) begin
          hi_d = rs_data;
        end else if (md_op == MD_MTLO) begin
          lo_d = rs_data;
        end
      end
      MD_RUN: begin
        // HI/LO stay frozen until the final edge, then commit together.
        if (cnt_q == CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          if (res_valid) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire
